// File: rtl/ltc2308_responder.sv
// ltc2308_responder: LTC2308 ADC emulator driving SDO from a parallel per-channel bus.
// Master pins are oversampled on clk; config words arrive on SDI and pick the next frame's channel.
module ltc2308_responder #(
   parameter int CONV_CYCLES = 80,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [95:0] ch_data,
   input  logic        adc_convst,
   input  logic        adc_sck,
   input  logic        adc_sdi,
   output logic        adc_sdo,
   output logic [5:0]  cfg_word,
   output logic        cfg_valid,
   output logic [2:0]  sample_ch,
   output logic        busy,
   output logic        frame_done
);
   localparam int CW = $clog2(CONV_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, CONVERT, SHIFT} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] cs_s, ck_s, di_s;
   logic cs_d, ck_d;
   logic cs_rise, ck_rise, ck_fall, sdi_bit;
   logic [2:0] ch;
   logic [11:0] chan [8];
   logic [11:0] shift;
   logic [5:0] rx;
   logic [2:0] rx_cnt;
   logic [3:0] tx_cnt;
   logic [CW-1:0] conv_cnt;
   for (genvar g = 0; g < 8; g++) begin : g_chan
      assign chan[g] = ch_data[12*g +: 12];
   end
   assign cs_rise = cs_s[SYNC_STAGES-1] & ~cs_d;
   assign ck_rise = ck_s[SYNC_STAGES-1] & ~ck_d;
   assign ck_fall = ~ck_s[SYNC_STAGES-1] & ck_d;
   assign sdi_bit = di_s[SYNC_STAGES-1];
   // channel = {S1,S0,O/S}
   assign ch = {cfg_word[3], cfg_word[2], cfg_word[4]};
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cs_s <= '0;
         ck_s <= '0;
         di_s <= '0;
         cs_d <= 1'b0;
         ck_d <= 1'b0;
      end else begin
         cs_s <= {cs_s[SYNC_STAGES-2:0], adc_convst};
         ck_s <= {ck_s[SYNC_STAGES-2:0], adc_sck};
         di_s <= {di_s[SYNC_STAGES-2:0], adc_sdi};
         cs_d <= cs_s[SYNC_STAGES-1];
         ck_d <= ck_s[SYNC_STAGES-1];
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         adc_sdo    <= 1'b0;
         cfg_word   <= 6'b100010;
         cfg_valid  <= 1'b0;
         sample_ch  <= 3'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         shift      <= '0;
         rx         <= '0;
         rx_cnt     <= '0;
         tx_cnt     <= '0;
         conv_cnt   <= '0;
      end else begin
         cfg_valid  <= 1'b0;
         frame_done <= 1'b0;
         // a CONVST rise restarts from any state; a partial config is simply dropped
         if (cs_rise) begin
            shift     <= chan[ch];
            sample_ch <= ch;
            busy      <= 1'b1;
            conv_cnt  <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            adc_sdo   <= 1'b0;
            state     <= CONVERT;
         end else begin
            case (state)
               CONVERT: begin
                  if (conv_cnt == CW'(CONV_CYCLES - 1)) begin
                     busy    <= 1'b0;
                     adc_sdo <= shift[11];
                     rx_cnt  <= '0;
                     tx_cnt  <= '0;
                     state   <= SHIFT;
                  end else begin
                     conv_cnt <= conv_cnt + 1'b1;
                  end
               end
               SHIFT: begin
                  if (ck_rise && rx_cnt < 3'd6) begin
                     rx     <= {rx[4:0], sdi_bit};
                     rx_cnt <= rx_cnt + 3'd1;
                     if (rx_cnt == 3'd5) begin
                        cfg_word  <= {rx[4:0], sdi_bit};
                        cfg_valid <= 1'b1;
                     end
                  end
                  if (ck_fall && tx_cnt < 4'd12) begin
                     tx_cnt  <= tx_cnt + 4'd1;
                     shift   <= {shift[10:0], 1'b0};
                     adc_sdo <= (tx_cnt == 4'd11) ? 1'b0 : shift[10];
                     if (tx_cnt == 4'd11) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ltc2308_responder.sv
// tb_ltc2308_responder: SPI-master model with a read-back scoreboard and a frame table.
module tb_ltc2308_responder;
   localparam int CC = 80;
   typedef struct {
      logic [5:0] cfg;
      logic [2:0] ch;
      logic [5:0] cfg_after;
   } vec_t;
   typedef struct packed {
      logic [11:0] d;
      logic [2:0]  ch;
   } exp_t;
   logic clk = 1'b0, reset_n = 1'b0, adc_convst = 1'b0, adc_sck = 1'b0, adc_sdi = 1'b0;
   logic [95:0] ch_data;
   logic adc_sdo, cfg_valid, busy, frame_done;
   logic [5:0] cfg_word;
   logic [2:0] sample_ch;
   int checks = 0, failures = 0;
   int fd_cnt = 0, cv_cnt = 0, busy_run = 0, busy_len = 0;
   logic [11:0] cv [8];
   vec_t tbl [7];
   exp_t sb [$];
   always #5 clk = ~clk;
   ltc2308_responder #(.CONV_CYCLES(CC), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .adc_convst(adc_convst),
      .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .cfg_word(cfg_word),
      .cfg_valid(cfg_valid), .sample_ch(sample_ch), .busy(busy), .frame_done(frame_done)
   );
   always @(negedge clk) begin
      fd_cnt   <= fd_cnt + ((frame_done === 1'b1) ? 1 : 0);
      cv_cnt   <= cv_cnt + ((cfg_valid === 1'b1) ? 1 : 0);
      busy_run <= (busy === 1'b1) ? busy_run + 1 : 0;
      if (busy !== 1'b1 && busy_run != 0) busy_len <= busy_run;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic set_ch();
      for (int i = 0; i < 8; i++) ch_data[12*i +: 12] = cv[i];
   endtask
   task automatic convert(input int junk);
      adc_convst = 1'b1;
      tick(4);
      adc_convst = 1'b0;
      adc_sdi = 1'b1;
      for (int j = 0; j < junk; j++) begin
         adc_sck = 1'b1;
         tick(3);
         adc_sck = 1'b0;
         tick(3);
      end
      tick(CC + 4 - 6 * junk);
   endtask
   task automatic clocks(input logic [5:0] cfg, input int n, output logic [15:0] rd);
      rd = '0;
      for (int k = 0; k < n; k++) begin
         adc_sdi = (k < 6) ? cfg[5-k] : 1'b0;
         tick(4);
         rd = {rd[14:0], adc_sdo};
         adc_sck = 1'b1;
         tick(4);
         adc_sck = 1'b0;
      end
      tick(6);
   endtask
   task automatic frame(input logic [5:0] cfg, input int n, input int junk,
                        input logic [5:0] cfg_after, input logic [2:0] ch);
      logic [15:0] rd;
      exp_t e;
      int f0, c0;
      sb.push_back('{d: cv[ch], ch: ch});
      f0 = fd_cnt;
      c0 = cv_cnt;
      convert(junk);
      chk("busy_len", busy_len, CC);
      chk("busy_low", busy, 0);
      clocks(cfg, n, rd);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("read_data", rd, 16'(e.d) << (n - 12));
         chk("sample_ch", sample_ch, e.ch);
      end
      chk("cfg_word", cfg_word, cfg_after);
      chk("cfg_valid_pulses", cv_cnt - c0, 1);
      chk("frame_done_pulses", fd_cnt - f0, 1);
      chk("sdo_idle", adc_sdo, 0);
   endtask
   initial begin
      logic [15:0] rd;
      int f0, c0;
      cv = '{12'hA5C, 12'h123, 12'h2B2, 12'h3C3, 12'h4D4, 12'h5E5, 12'h6F6, 12'h707};
      set_ch();
      tbl[0] = '{6'b110010, 3'd0, 6'b110010};
      tbl[1] = '{6'b111010, 3'd1, 6'b111010};
      tbl[2] = '{6'b110010, 3'd5, 6'b110010};
      tbl[3] = '{6'b111010, 3'd1, 6'b111010};
      tbl[4] = '{6'b100110, 3'd5, 6'b100110};
      tbl[5] = '{6'b101100, 3'd2, 6'b101100};
      tbl[6] = '{6'b100010, 3'd6, 6'b100010};
      tick(3);
      chk("rst_sdo", adc_sdo, 0);
      chk("rst_cfg", cfg_word, 6'b100010);
      chk("rst_flags", {cfg_valid, busy, frame_done}, 0);
      chk("rst_ch", sample_ch, 0);
      reset_n = 1'b1;
      tick(2);
      for (int i = 0; i < 7; i++) frame(tbl[i].cfg, 12, 0, tbl[i].cfg_after, tbl[i].ch);
      // abort after 3 SCKs: new partial word dropped, fresh sample taken
      convert(0);
      clocks(6'b111110, 3, rd);
      c0 = cv_cnt;
      f0 = fd_cnt;
      cv[0] = 12'h5A3;
      set_ch();
      sb.push_back('{d: 12'h5A3, ch: 3'd0});
      convert(0);
      chk("abort_busy_len", busy_len, CC);
      chk("abort_cfg", cfg_word, 6'b100010);
      chk("abort_no_valid", cv_cnt - c0, 0);
      chk("abort_no_done", fd_cnt - f0, 0);
      cv[0] = 12'hFFF;
      set_ch();
      clocks(6'b100010, 12, rd);
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else chk("abort_read", rd[11:0], sb.pop_front().d);
      chk("abort_done", fd_cnt - f0, 1);
      cv[0] = 12'hA5C;
      set_ch();
      // SCK during CONVERT, then 16 SCKs
      frame(6'b110010, 16, 5, 6'b110010, 3'd0);
      // reset mid-SHIFT
      convert(0);
      clocks(6'b111010, 4, rd);
      chk("pre_rst_ch", sample_ch, 1);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      chk("mid_rst_sdo", adc_sdo, 0);
      chk("mid_rst_cfg", cfg_word, 6'b100010);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ch", sample_ch, 0);
      tick(2);
      f0 = fd_cnt;
      clocks(6'b111111, 4, rd);
      chk("idle_sck_sdo", rd, 0);
      chk("idle_sck_done", fd_cnt - f0, 0);
      frame(6'b100010, 12, 0, 6'b100010, 3'd0);
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
